// File: rtl/io_pins_sampler.sv
// Pin input stage: per-pin synchronizer and debouncer, sticky change flags,
// byte-level direction masking and a freezable image for coherent MCU reads.
module io_pins_sampler #(
    parameter int PINS_CONT       = 128,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int NB  = PINS_CONT / 8,
    localparam int CBW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                 CLK50,
    input  logic                 rst_n,
    input  logic [PINS_CONT-1:0] pins_in,
    input  logic [NB-1:0]        write_read,
    input  logic                 freeze,
    input  logic                 clr_valid,
    input  logic [CBW-1:0]       clr_byte,
    input  logic [7:0]           clr_mask,
    input  logic [PINS_CONT-1:0] irq_en,
    output logic [PINS_CONT-1:0] data_out,
    output logic [PINS_CONT-1:0] change_flags,
    output logic                 irq
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][PINS_CONT-1:0] r_sync;
    logic [PINS_CONT-1:0][7:0]             r_cnt;
    logic [PINS_CONT-1:0][7:0]             w_cnt_nxt;
    logic [PINS_CONT-1:0]                  w_sync;
    logic [PINS_CONT-1:0]                  r_stable;
    logic [PINS_CONT-1:0]                  w_stable_nxt;
    logic [PINS_CONT-1:0]                  w_set;
    logic [PINS_CONT-1:0]                  w_clr;
    logic [PINS_CONT-1:0]                  r_flags;
    logic [PINS_CONT-1:0]                  r_data;
    logic [PINS_CONT-1:0]                  w_data_nxt;
    logic                                  r_irq;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Byte indices past NB never match, so out-of-range clears do nothing.
    always_comb begin
        w_stable_nxt = r_stable;
        w_cnt_nxt    = r_cnt;
        w_set        = '0;
        w_clr        = '0;
        w_data_nxt   = r_data;
        for (int b = 0; b < NB; b++) begin
            if (clr_valid && (clr_byte == CBW'(b))) begin
                w_clr[b*8 +: 8] = clr_mask;
            end
            if (!freeze && !write_read[b]) begin
                w_data_nxt[b*8 +: 8] = r_stable[b*8 +: 8];
            end
            for (int k = 0; k < 8; k++) begin
                if (write_read[b]) begin
                    w_cnt_nxt[b*8+k] = '0;
                end else if (w_sync[b*8+k] == r_stable[b*8+k]) begin
                    w_cnt_nxt[b*8+k] = '0;
                end else if (r_cnt[b*8+k] == CNT_LAST) begin
                    w_stable_nxt[b*8+k] = w_sync[b*8+k];
                    w_cnt_nxt[b*8+k]    = '0;
                    w_set[b*8+k]        = 1'b1;
                end else begin
                    w_cnt_nxt[b*8+k] = r_cnt[b*8+k] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK50) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
            r_flags  <= '0;
            r_data   <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], pins_in};
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
            // A set pulse overrides a clear on the same pin.
            r_flags  <= (r_flags & ~w_clr) | w_set;
            r_data   <= w_data_nxt;
            r_irq    <= |(r_flags & irq_en);
        end
    end

    assign data_out     = r_data;
    assign change_flags = r_flags;
    assign irq          = r_irq;

endmodule

// File: tb/tb_io_pins_sampler.sv
// Directed bench for io_pins_sampler: vector table for pulse widths and
// masking, hand sequences for reset, latency, clear priority and freeze.
module tb_io_pins_sampler;

    logic         CLK50 = 1'b0;
    logic         rst_n;
    logic [127:0] pins_in;
    logic [15:0]  write_read;
    logic         freeze;
    logic         clr_valid;
    logic [3:0]   clr_byte;
    logic [7:0]   clr_mask;
    logic [127:0] irq_en;
    logic [127:0] data_out;
    logic [127:0] change_flags;
    logic         irq;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          pin;
        int          len;
        logic [15:0] wr;
        bit          perm;
        logic        exp_flag;
        logic        exp_data;
    } vec_t;

    vec_t vecs[9];

    io_pins_sampler dut (
        .CLK50        (CLK50),
        .rst_n        (rst_n),
        .pins_in      (pins_in),
        .write_read   (write_read),
        .freeze       (freeze),
        .clr_valid    (clr_valid),
        .clr_byte     (clr_byte),
        .clr_mask     (clr_mask),
        .irq_en       (irq_en),
        .data_out     (data_out),
        .change_flags (change_flags),
        .irq          (irq)
    );

    always #5 CLK50 = ~CLK50;

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_all();
        for (int b = 0; b < 16; b++) begin
            clr_valid = 1'b1;
            clr_byte  = 4'(b);
            clr_mask  = 8'hff;
            tick();
        end
        clr_valid = 1'b0;
        clr_mask  = 8'h00;
    endtask

    initial begin
        logic [127:0] one;
        logic         orig;
        vecs[0] = '{20,  3, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{20,  4, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{33,  2, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{33, 20, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{33, 20, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{127, 1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{0,  20, 16'h0001, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{127,20, 16'h7fff, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{64,  4, 16'h0100, 1'b0, 1'b0, 1'b1};

        rst_n      = 1'b0;
        pins_in    = '1;
        write_read = '0;
        freeze     = 1'b0;
        clr_valid  = 1'b0;
        clr_byte   = '0;
        clr_mask   = '0;
        irq_en     = '1;

        // Reset and first-image latency
        ticks(3);
        check("reset_data", data_out, '0);
        check("reset_flags", change_flags, '0);
        check("reset_irq", 128'(irq), '0);
        rst_n = 1'b1;
        ticks(6);
        check("post_rst_data_e6", data_out, '0);
        check("post_rst_flags_e6", change_flags, '1);
        check("post_rst_irq_e6", 128'(irq), '0);
        tick();
        check("post_rst_data_e7", data_out, '1);
        check("post_rst_irq_e7", 128'(irq), 128'd1);

        // irq falls one edge after the last flag clears
        clear_all();
        check("clr_all_flags", change_flags, '0);
        check("clr_all_irq_lag", 128'(irq), 128'd1);
        tick();
        check("clr_all_irq", 128'(irq), '0);

        // Latency of a single rising pin
        pins_in[5] = 1'b0;
        ticks(10);
        clear_all();
        ticks(2);
        pins_in[5] = 1'b1;
        ticks(5);
        check("lat_flag_early", change_flags, '0);
        tick();
        check("lat_flag", change_flags, 128'd1 << 5);
        check("lat_data_early", 128'(data_out[5]), '0);
        check("lat_irq_early", 128'(irq), '0);
        tick();
        check("lat_data", 128'(data_out[5]), 128'd1);
        check("lat_irq", 128'(irq), 128'd1);

        // Table: pulse widths and masked bytes
        for (int v = 0; v < 9; v++) begin
            clear_all();
            ticks(2);
            write_read = vecs[v].wr;
            orig = pins_in[vecs[v].pin];
            pins_in[vecs[v].pin] = ~orig;
            ticks(vecs[v].len);
            if (!vecs[v].perm) pins_in[vecs[v].pin] = orig;
            ticks(15);
            one = 128'd1 << vecs[v].pin;
            check($sformatf("vec%0d_flag", v),
                  128'(change_flags[vecs[v].pin]), 128'(vecs[v].exp_flag));
            check($sformatf("vec%0d_data", v),
                  128'(data_out[vecs[v].pin]), 128'(vecs[v].exp_data));
            check($sformatf("vec%0d_others", v), change_flags & ~one, '0);
            if (vecs[v].wr != 16'h0000) begin
                pins_in[vecs[v].pin] = orig;
                ticks(10);
                write_read = '0;
                ticks(2);
            end
        end

        // Masked byte, then unmask with new level already present
        ticks(10);
        clear_all();
        ticks(2);
        write_read = 16'h0004;
        pins_in[23:16] = 8'h00;
        ticks(10);
        check("mask_data", 128'(data_out[23:16]), 128'hff);
        check("mask_flags", change_flags, '0);
        write_read = 16'h0000;
        ticks(4);
        check("unmask_data_e4", 128'(data_out[23:16]), 128'hff);
        check("unmask_flags_e4", change_flags, 128'hff << 16);
        tick();
        check("unmask_data_e5", 128'(data_out[23:16]), 128'h00);

        // Clear colliding with a set pulse, then a plain clear
        clear_all();
        ticks(2);
        pins_in[40] = 1'b0;
        ticks(5);
        clr_valid = 1'b1;
        clr_byte  = 4'd5;
        clr_mask  = 8'h01;
        tick();
        clr_valid = 1'b0;
        check("set_wins", 128'(change_flags[40]), 128'd1);
        ticks(2);
        check("set_wins_irq", 128'(irq), 128'd1);
        clr_valid = 1'b1;
        tick();
        clr_valid = 1'b0;
        check("plain_clear", 128'(change_flags[40]), '0);
        check("plain_clear_irq_lag", 128'(irq), 128'd1);
        tick();
        check("plain_clear_irq", 128'(irq), '0);

        // Freeze holds the image while flags keep moving
        freeze = 1'b1;
        pins_in[100] = 1'b0;
        ticks(10);
        check("freeze_data", 128'(data_out[100]), 128'd1);
        check("freeze_flag", 128'(change_flags[100]), 128'd1);
        check("freeze_irq", 128'(irq), 128'd1);
        freeze = 1'b0;
        tick();
        check("unfreeze_data", 128'(data_out[100]), '0);

        // Reset again from a mixed image
        rst_n = 1'b0;
        tick();
        check("rst2_data", data_out, '0);
        check("rst2_flags", change_flags, '0);
        rst_n = 1'b1;
        ticks(6);
        check("rst2_flags_e6", change_flags, pins_in);
        check("rst2_data_e6", data_out, '0);
        tick();
        check("rst2_data_e7", data_out, pins_in);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/io_pins_sampler.md
Name: io_pins_sampler

Overview:
- Input-side stage between the 128 external io_pins and the 16x8 input register bank that the MCU bus interface reads.
- Synchronizes each pin to CLK50 and debounces it.
- Presents the filtered pin image as 16 bytes, keeps sticky per-pin change flags, and raises an interrupt toward the MCU.
- Bytes configured as outputs by the direction word are masked from sampling.

Parameters:
- PINS_CONT, 128, number of pins; must be a multiple of 8 (byte count NB = PINS_CONT/8).
- SYNC_STAGES, 2, synchronizer flops per pin; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized level must differ from the stable level before it is accepted; legal range 1..255.

Ports:
- CLK50  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- pins_in  input  PINS_CONT  raw asynchronous pin levels.
- write_read  input  NB  direction per byte; bit b=1 means byte b (pins 8b+7..8b) is output, so it is masked.
- freeze  input  1  1 holds data_out for a coherent multi-byte MCU read.
- clr_valid  input  1  flag-clear strobe, one cycle.
- clr_byte  input  log2(NB)  byte index for the clear.
- clr_mask  input  8  bits of that byte whose flags are cleared.
- irq_en  input  PINS_CONT  per-pin interrupt enable.
- data_out  output  PINS_CONT  filtered pin image; byte b feeds input register b.
- change_flags  output  PINS_CONT  sticky per-pin change flags.
- irq  output  1  registered OR of (change_flags & irq_en).

Behaviour:
- Reset, sampled when rst_n=0 on a clock edge:
  - All synchronizer flops, stable levels, debounce counters, data_out, change_flags and irq go to 0.
  - Reset takes priority over every other input.
  - Reset asserted mid-debounce discards the partial count.
- Synchronizer: SYNC_STAGES-deep shift chain per pin; sync[i] is the last stage.
- Debounce, per pin i, unmasked byte:
  - If sync[i]==stable[i]: cnt <= 0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable[i] <= sync[i], cnt <= 0, flag set pulse for pin i.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes stable.
  - Counter width is 8 bits; it never wraps because it resets at the terminal value.
- Masked byte, write_read[b]=1:
  - stable and cnt for its 8 pins are held; cnt is forced to 0.
  - No flag set pulses for those pins.
  - data_out byte b holds its last value.
  - When the byte returns to input, debounce restarts from cnt=0 against the held stable value.
- data_out:
  - Registered copy of stable when freeze=0.
  - While freeze=1, data_out holds its value; stable, flags and irq keep updating.
  - On freeze falling, data_out follows stable on the next edge.
- Latency, pin edge (set up before edge 1) to data_out: SYNC_STAGES+DEBOUNCE_CYCLES+1 edges, 7 with defaults. change_flags sets one edge earlier; irq sets on the same edge as data_out.
- change_flags:
  - Set by the set pulse.
  - Cleared for pins 8*clr_byte+k where clr_mask[k]=1 and clr_valid=1.
  - Set and clear on the same pin in the same cycle: set wins, flag stays 1.
  - clr_byte >= NB is ignored.
- irq <= |(change_flags & irq_en), one-cycle registered. Clearing the last enabled flag drops irq one edge after the flag clears.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with pins_in=all 1s -> data_out, change_flags and irq are 0. After release, data_out=all 1s exactly 7 edges later; flags for all 128 pins are set and, with irq_en=all 1s, irq=1.
- Latency: after settle, pins_in[5] 0->1 before edge N -> change_flags[5]=1 after edge N+5, data_out[5]=1 and irq=1 after edge N+6; no other flag changes.
- Glitch rejection: pins_in[20] high for 3 cycles, then low -> data_out[20] and change_flags[20] stay 0. A 4-cycle pulse is accepted, and its return to low is accepted 4 synchronized cycles later.
- Masking: write_read=16'h0004, toggle pins 16..23 -> byte 2 of data_out unchanged, no flags. Clear bit 2 while pins hold the new value -> data_out byte 2 updates 5 edges later (DEBOUNCE_CYCLES+1).
- Clear vs set: flag[40] set; clr_valid=1, clr_byte=5, clr_mask=8'h01 on the cycle a new set pulse for pin 40 occurs -> flag[40] remains 1. Repeat without a set pulse -> flag[40]=0 and irq=0 on the next edge.
- Freeze: freeze=1, toggle pin 100 -> data_out[100] unchanged but change_flags[100]=1. Drop freeze -> data_out[100] updates on the next edge.
